// File: rtl/ac2_shift_acc_multi.sv
// ac2_shift_acc_multi: N-lane shift-and-add accumulator for bit-serial dot products.
// Each lane adds one signed partial sum per weight bit (LSB first) into the upper
// part of its accumulator and shifts right; after Pw accepted bits the accumulator
// holds sum_k ps_k * 2^k and is presented under a valid/ready handshake.
// Build option: define AC2_SIGNED_W_EN for two's-complement weights (the MSB
// weight bit subtracts); leave it undefined for unsigned weights.
module ac2_shift_acc_multi #(
  parameter  int M  = 16,
  parameter  int Pa = 8,
  parameter  int Pw = 4,
  parameter  int N  = 4,
  localparam int PS = $clog2(M) + Pa + 1,
  localparam int W  = PS + Pw,
  localparam int CW = $clog2(Pw)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cl_en,
  input  logic            start,
  input  logic            valid,
  input  logic [N*PS-1:0] inr_ac2,
  output logic [CW-1:0]   w_bit_idx,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  outr_ac2
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(Pw - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_clr;   // zero every lane accumulator this cycle
  logic          acc_step;  // every lane absorbs its partial sum this cycle

`ifdef AC2_SIGNED_W_EN
  logic          last_bit;  // the bit being absorbed carries negative weight
  assign last_bit = (cnt_q == LAST_BIT);
`endif

  // State and weight-bit counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter sequencing; clear beats every other request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cl_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
          end
        end
        S_SHIFT: begin
          if (valid) begin
            if (cnt_q == LAST_BIT) begin
              state_d = S_HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d = start ? S_SHIFT : S_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Status decodes from registered state plus datapath strobes
  always_comb begin
    busy      = (state_q == S_SHIFT);
    out_valid = (state_q == S_HOLD);
    w_bit_idx = cnt_q;
    acc_clr   = cl_en
              | ((state_q == S_IDLE) & start)
              | ((state_q == S_HOLD) & out_ready & start);
    acc_step  = ~cl_en & (state_q == S_SHIFT) & valid;
  end

  // Per-lane accumulator datapath
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [W-1:0]       acc_q, acc_d;
      logic signed [PS:0] hi_ext;
      logic signed [PS:0] in_ext;
      logic signed [PS:0] sum;

      // Widen both operands by one bit so the add/sub cannot overflow
      always_comb begin
        hi_ext = {acc_q[W-1], acc_q[W-1:Pw]};
        in_ext = {inr_ac2[gi*PS + PS - 1], inr_ac2[gi*PS +: PS]};
`ifdef AC2_SIGNED_W_EN
        sum    = last_bit ? (hi_ext - in_ext) : (hi_ext + in_ext);
`else
        sum    = hi_ext + in_ext;
`endif
        acc_d  = acc_q;
        if (acc_clr) begin
          acc_d = '0;
        end else if (acc_step) begin
          // Dropping acc_q[0] is exact: the bits shifted out are always zero
          acc_d = {sum, acc_q[Pw-1:1]};
        end
      end

      // Accumulator register, cleared asynchronously by reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end

      assign outr_ac2[gi*W +: W] = acc_q;
    end
  endgenerate

endmodule

// File: tb/tb_ac2_shift_acc_multi.sv
// Self-checking bench for ac2_shift_acc_multi. A behavioural model sums
// ps_k * 2^k per lane (negating the MSB term when AC2_SIGNED_W_EN is defined)
// and tracks idle / collecting / holding; a negedge process compares the DUT
// against it every cycle. Directed literals pin the model.
module tb_ac2_shift_acc_multi;

  localparam int M  = 16;
  localparam int PA = 8;
  localparam int PW = 4;
  localparam int N  = 4;
  localparam int PS = $clog2(M) + PA + 1;
  localparam int W  = PS + PW;
  localparam int CW = $clog2(PW);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cl_en = 1'b0;
  logic            start = 1'b0;
  logic            valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [N*PS-1:0] inr = '0;
  logic [CW-1:0]   w_bit_idx;
  logic            busy;
  logic            out_valid;
  logic [N*W-1:0]  outr;

  int checks = 0;
  int errors = 0;
  int words  = 0;

  always #5 clk = ~clk;

  ac2_shift_acc_multi #(.M(M), .Pa(PA), .Pw(PW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .cl_en(cl_en), .start(start), .valid(valid),
    .inr_ac2(inr), .w_bit_idx(w_bit_idx), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .outr_ac2(outr)
  );

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [63:0] lane_out(input int i);
    logic signed [W-1:0] v;
    v = outr[i*W +: W];
    return v;
  endfunction

  function automatic logic signed [63:0] lane_in(input int i);
    logic signed [PS-1:0] v;
    v = inr[i*PS +: PS];
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  int                 m_phase;   // 0 idle, 1 collecting bits, 2 holding result
  int                 m_k;       // weight bits accepted so far in this word
  logic signed [63:0] m_res [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_k     = 0;
      for (int i = 0; i < N; i++) m_res[i] = 0;
    end else if (cl_en) begin
      m_phase = 0;
      m_k     = 0;
      for (int i = 0; i < N; i++) m_res[i] = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_k     = 0;
          for (int i = 0; i < N; i++) m_res[i] = 0;
        end
        1: if (valid) begin
          logic signed [63:0] wgt;
          wgt = 64'sd1 <<< m_k;
`ifdef AC2_SIGNED_W_EN
          if (m_k == PW - 1) wgt = -wgt;
`endif
          for (int i = 0; i < N; i++) m_res[i] = m_res[i] + lane_in(i) * wgt;
          m_k = m_k + 1;
          if (m_k == PW) begin
            m_phase = 2;
            m_k     = 0;
          end
        end
        default: if (out_ready) begin
          words++;
          $display("word %0d accepted: lane0=%0d lane1=%0d lane2=%0d lane3=%0d",
                   words, lane_out(0), lane_out(1), lane_out(2), lane_out(3));
          if (start) begin
            m_phase = 1;
            for (int i = 0; i < N; i++) m_res[i] = 0;
          end else begin
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", busy, m_phase == 1);
    chk("out_valid", out_valid, m_phase == 2);
    chk("w_bit_idx", w_bit_idx, m_k);
    if (m_phase == 2)
      for (int i = 0; i < N; i++) chk($sformatf("outr_lane%0d", i), lane_out(i), m_res[i]);
  end

  // ---------------- stimulus ----------------
  logic signed [PS-1:0] ps_tab [N][PW];
  logic signed [63:0]   exp_a [N];
  logic signed [63:0]   exp_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inr();
    for (int i = 0; i < N; i++) inr[i*PS +: PS] = PS'($urandom);
  endtask

  task automatic start_word();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int k);
    valid = 1'b1;
    for (int i = 0; i < N; i++) inr[i*PS +: PS] = ps_tab[i][k];
    tick();
    valid = 1'b0;
    scramble_inr();
  endtask

  task automatic load_tab_a();
    for (int k = 0; k < PW; k++) begin
      ps_tab[0][k] = 13'sd5;
      ps_tab[1][k] = -13'sd3;
      ps_tab[2][k] = (k == PW - 1) ? -13'sd4096 : 13'sd4095;
    end
    ps_tab[3][0] = 13'sd1;
    ps_tab[3][1] = -13'sd1;
    ps_tab[3][2] = 13'sd2;
    ps_tab[3][3] = -13'sd2;
  endtask

  task automatic check_hold(input string tag, input logic signed [63:0] e0,
                            input logic signed [63:0] e1, input logic signed [63:0] e2,
                            input logic signed [63:0] e3);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_lane0"}, lane_out(0), e0);
    chk({tag, "_lane1"}, lane_out(1), e1);
    chk({tag, "_lane2"}, lane_out(2), e2);
    chk({tag, "_lane3"}, lane_out(3), e3);
    chk({tag, "_model_lane0"}, m_res[0], e0);
    chk({tag, "_model_lane2"}, m_res[2], e2);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_w_bit_idx"}, w_bit_idx, 0);
    for (int i = 0; i < N; i++) chk($sformatf("%s_outr_lane%0d", tag, i), lane_out(i), 0);
  endtask

  initial begin
    int pat [7];
    int kk;
`ifdef AC2_SIGNED_W_EN
    exp_a[0] = -5;  exp_a[1] = 3;   exp_a[2] = 61433; exp_a[3] = 23;  exp_b = -1;
`else
    exp_a[0] = 75;  exp_a[1] = -45; exp_a[2] = -4103; exp_a[3] = -9;  exp_b = 15;
`endif
    pat = '{1, 0, 0, 1, 1, 0, 1};
    scramble_inr();

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Word A: back-to-back valids, minimum latency
    load_tab_a();
    start_word();
    chk("A_busy_after_start", busy, 1);
    for (int k = 0; k < PW; k++) feed(k);
    check_hold("A", exp_a[0], exp_a[1], exp_a[2], exp_a[3]);

    // Consumer back-pressure: result must stay put
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("A_stall_out_valid", out_valid, 1);
      chk("A_stall_lane0", lane_out(0), exp_a[0]);
    end

    // Handshake with start: next word starts immediately
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("B_busy_after_handshake", busy, 1);
    chk("B_idx_after_handshake", w_bit_idx, 0);

    // Word B: ps=1 everywhere with stalls on valid
    for (int i = 0; i < N; i++)
      for (int k = 0; k < PW; k++) ps_tab[i][k] = 13'sd1;
    kk = 0;
    for (int j = 0; j < 7; j++) begin
      if (pat[j] == 1) begin
        feed(kk);
        kk++;
      end else begin
        tick();
      end
    end
    check_hold("B", exp_b, exp_b, exp_b, exp_b);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("B_idle_busy", busy, 0);
    chk("B_idle_out_valid", out_valid, 0);

    // Clear mid-word, then a fresh word must match the reference
    for (int i = 0; i < N; i++)
      for (int k = 0; k < PW; k++) ps_tab[i][k] = PS'($urandom);
    start_word();
    feed(0);
    feed(1);
    cl_en = 1'b1;
    start = 1'b1;
    valid = 1'b1;
    tick();
    cl_en = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    check_all_zero("clear");
    cl_en = 1'b1;
    start = 1'b1;
    tick();
    cl_en = 1'b0;
    start = 1'b0;
    chk("clear_start_ignored", busy, 0);
    load_tab_a();
    start_word();
    for (int k = 0; k < PW; k++) feed(k);
    check_hold("C", exp_a[0], exp_a[1], exp_a[2], exp_a[3]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Random words with random stalls and hold times, chained by handshake-start
    start_word();
    for (int w = 0; w < 6; w++) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < PW; k++) ps_tab[i][k] = PS'($urandom);
      for (int k = 0; k < PW; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        feed(k);
      end
      repeat ($urandom_range(0, 2)) tick();
      out_ready = 1'b1;
      start     = (w != 5);
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
    end

    // Asynchronous reset mid-word; valid alone must not restart
    load_tab_a();
    start_word();
    feed(0);
    feed(1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    tick();
    rst_n = 1'b1;
    valid = 1'b1;
    repeat (3) tick();
    valid = 1'b0;
    chk("rst_mid_valid_ignored_busy", busy, 0);
    chk("rst_mid_valid_ignored_idx", w_bit_idx, 0);

    // Asynchronous reset during HOLD
    start_word();
    for (int k = 0; k < PW; k++) feed(k);
    check_hold("D", exp_a[0], exp_a[1], exp_a[2], exp_a[3]);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_hold");
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
